uart_mem_cmd_engine: RTL and testbench
======================================

// Module: uart_mem_cmd_engine
//
// PURPOSE
// UART-domain command engine that turns a byte stream from the UART receiver into single-word
// SRAM read/write requests for the UART side of the SRAM CDC bridge, and returns results to
// the UART transmitter. Owns the bridge request pulses, waits for the bridge done pulse, and
// also drives the bridge's level bus-ownership request (u_req). Runs entirely in u_clk.
//
// PARAMETERS
// IDLE_TIMEOUT  1000000  u_clk cycles without a byte that abort a partially received frame
// ACK_BYTE      8'h4B    response to W/G/F commands ('K')
// ERR_BYTE      8'h45    response to an unknown opcode ('E')
//
// PORTS
// u_clk      in   1   UART-domain clock
// u_rst_n    in   1   asynchronous active-low reset
// rx_data    in   8   received byte, valid when rx_valid=1
// rx_valid   in   1   one-cycle strobe per received byte, no backpressure
// tx_data    out  8   byte to transmit
// tx_valid   out  1   tx_data valid; held with tx_data stable until tx_ready
// tx_ready   in   1   transmitter accepts byte when tx_valid&&tx_ready
// u_req      out  1   level bus-ownership request to bridge
// u_wr_req   out  1   one-cycle write pulse to bridge
// u_rd_req   out  1   one-cycle read pulse to bridge
// u_addr     out  16  word address, stable from pulse until u_done
// u_wdata    out  16  write data, stable from pulse until u_done
// u_rdata    in   16  read data from bridge, valid in the u_done cycle
// u_done     in   1   one-cycle completion pulse from bridge
// u_busy     in   1   bridge busy; pulses issued only while low
// rx_overrun out  1   sticky: byte arrived while engine could not accept it
//
// BEHAVIOUR
// - Reset (u_rst_n=0, async): all outputs 0, state IDLE, arg index 0, timeout counter 0.
// - Frames (big-endian): 'W'(57) AH AL DH DL; 'R'(52) AH AL; 'G'(47) set u_req=1; 'F'(46) clear.
//   Responses: W,G,F -> ACK_BYTE; R -> DH then DL; other opcode -> ERR_BYTE, no bus activity.
// - States: IDLE -> ARGS (W/R) | RESP (G/F/unknown); ARGS -> ISSUE after last arg byte;
//   ISSUE -> WAIT_DONE on pulse; WAIT_DONE -> RESP on u_done; RESP -> IDLE after last byte accepted.
// - ARGS: byte N shifts into addr/data hold regs; timeout counter cleared on each rx_valid,
//   increments otherwise; reaching IDLE_TIMEOUT-1 -> IDLE, frame dropped, no response.
// - ISSUE: if u_busy=0, assert u_wr_req or u_rd_req for exactly one cycle, u_addr/u_wdata
//   updated on same edge; if u_busy=1, wait. Earliest pulse: cycle after last arg byte strobe.
// - WAIT_DONE: no timeout; on u_done capture u_rdata; tx_valid rises next cycle with first byte.
// - G/F: u_req updated on the edge accepting the opcode; ACK tx_valid rises next cycle.
// - RESP: tx_data advances only on tx_valid&&tx_ready; tx_valid drops the cycle after the last
//   handshake; no byte ever dropped or repeated.
// - rx_valid in ISSUE/WAIT_DONE/RESP: byte discarded, rx_overrun<=1 (sticky until reset).
// - u_done outside WAIT_DONE: ignored. u_wr_req and u_rd_req never high together.
// - Reset mid-operation: engine returns to IDLE immediately; bridge reset is the caller's concern.
//
// TESTING
// - Bytes 57 12 34 BE EF -> one u_wr_req, u_addr=1234, u_wdata=BEEF; u_done -> tx 4B only.
// - Bytes 52 00 10, u_done with u_rdata=A55A -> one u_rd_req, u_addr=0010; tx A5 then 5A.
// - u_busy=1 for 20 cycles at ISSUE -> no pulse until cycle after u_busy falls; exactly one pulse.
// - tx_ready=0 for 10 cycles during R response -> tx_data=A5 held stable, then A5,5A once each.
// - 57 12 then silence IDLE_TIMEOUT cycles, then 52 00 01 -> first frame dropped, read of 0001.
// - 47 -> u_req=1, tx 4B; 99 -> tx 45; rx byte during WAIT_DONE -> rx_overrun=1, frame unaffected.

Source files
------------

// File: rtl/uart_mem_cmd_engine_if.sv
// UART-side SRAM bridge bus: single-word request pulses, completion pulse and
// the level bus-ownership request.
interface uart_mem_cmd_engine_if;
    logic        u_req;
    logic        u_wr_req;
    logic        u_rd_req;
    logic [15:0] u_addr;
    logic [15:0] u_wdata;
    logic [15:0] u_rdata;
    logic        u_done;
    logic        u_busy;

    modport master (
        output u_req, u_wr_req, u_rd_req, u_addr, u_wdata,
        input  u_rdata, u_done, u_busy
    );

    modport slave (
        input  u_req, u_wr_req, u_rd_req, u_addr, u_wdata,
        output u_rdata, u_done, u_busy
    );
endinterface

// File: rtl/uart_mem_cmd_engine.sv
// Byte-stream command engine: decodes W/R/G/F frames from the UART receiver,
// drives single-word SRAM bridge requests and returns ACK/ERR/read data bytes.
module uart_mem_cmd_engine #(
    parameter int unsigned IDLE_TIMEOUT = 1000000,
    parameter logic [7:0]  ACK_BYTE     = 8'h4B,
    parameter logic [7:0]  ERR_BYTE     = 8'h45
) (
    input  logic                         u_clk,
    input  logic                         u_rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         rx_overrun,
    uart_mem_cmd_engine_if.master        bus
);
    localparam int unsigned      TW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0]    TO_LAST = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARGS      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t         state_r,     state_s;
    logic           is_wr_r,     is_wr_s;
    logic [1:0]     arg_idx_r,   arg_idx_s;
    logic [TW-1:0]  timeout_r,   timeout_s;
    logic [15:0]    addr_hold_r, addr_hold_s;
    logic [15:0]    data_hold_r, data_hold_s;
    logic [7:0]     resp_lo_r,   resp_lo_s;
    logic           resp_two_r,  resp_two_s;
    logic [7:0]     tx_data_r,   tx_data_s;
    logic           tx_valid_r,  tx_valid_s;
    logic           u_req_r,     u_req_s;
    logic           u_wr_req_r,  u_wr_req_s;
    logic           u_rd_req_r,  u_rd_req_s;
    logic [15:0]    u_addr_r,    u_addr_s;
    logic [15:0]    u_wdata_r,   u_wdata_s;
    logic           overrun_r,   overrun_s;
    logic           last_arg_s;

    // State and all registered outputs; everything clears on async reset.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_r     <= ST_IDLE;
            is_wr_r     <= 1'b0;
            arg_idx_r   <= 2'd0;
            timeout_r   <= '0;
            addr_hold_r <= 16'h0000;
            data_hold_r <= 16'h0000;
            resp_lo_r   <= 8'h00;
            resp_two_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            u_req_r     <= 1'b0;
            u_wr_req_r  <= 1'b0;
            u_rd_req_r  <= 1'b0;
            u_addr_r    <= 16'h0000;
            u_wdata_r   <= 16'h0000;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            is_wr_r     <= is_wr_s;
            arg_idx_r   <= arg_idx_s;
            timeout_r   <= timeout_s;
            addr_hold_r <= addr_hold_s;
            data_hold_r <= data_hold_s;
            resp_lo_r   <= resp_lo_s;
            resp_two_r  <= resp_two_s;
            tx_data_r   <= tx_data_s;
            tx_valid_r  <= tx_valid_s;
            u_req_r     <= u_req_s;
            u_wr_req_r  <= u_wr_req_s;
            u_rd_req_r  <= u_rd_req_s;
            u_addr_r    <= u_addr_s;
            u_wdata_r   <= u_wdata_s;
            overrun_r   <= overrun_s;
        end
    end

    assign last_arg_s = is_wr_r ? (arg_idx_r == 2'd3) : (arg_idx_r == 2'd1);

    // Next-state and next-output decode; request pulses default low so they last one cycle.
    always_comb begin
        state_s     = state_r;
        is_wr_s     = is_wr_r;
        arg_idx_s   = arg_idx_r;
        timeout_s   = timeout_r;
        addr_hold_s = addr_hold_r;
        data_hold_s = data_hold_r;
        resp_lo_s   = resp_lo_r;
        resp_two_s  = resp_two_r;
        tx_data_s   = tx_data_r;
        tx_valid_s  = tx_valid_r;
        u_req_s     = u_req_r;
        u_wr_req_s  = 1'b0;
        u_rd_req_s  = 1'b0;
        u_addr_s    = u_addr_r;
        u_wdata_s   = u_wdata_r;
        overrun_s   = overrun_r;

        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    arg_idx_s  = 2'd0;
                    timeout_s  = '0;
                    resp_two_s = 1'b0;
                    case (rx_data)
                        8'h57: begin
                            is_wr_s = 1'b1;
                            state_s = ST_ARGS;
                        end
                        8'h52: begin
                            is_wr_s = 1'b0;
                            state_s = ST_ARGS;
                        end
                        8'h47, 8'h46: begin
                            u_req_s    = (rx_data == 8'h47);
                            tx_data_s  = ACK_BYTE;
                            tx_valid_s = 1'b1;
                            state_s    = ST_RESP;
                        end
                        default: begin
                            tx_data_s  = ERR_BYTE;
                            tx_valid_s = 1'b1;
                            state_s    = ST_RESP;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARGS: begin
                if (rx_valid) begin
                    timeout_s = '0;
                    arg_idx_s = arg_idx_r + 2'd1;
                    if (arg_idx_r < 2'd2) begin
                        addr_hold_s = {addr_hold_r[7:0], rx_data};
                    end else begin
                        data_hold_s = {data_hold_r[7:0], rx_data};
                    end
                    if (last_arg_s) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_ARGS;
                    end
                end else if (timeout_r == TO_LAST) begin
                    // Silent line mid-frame: drop the partial frame without answering.
                    timeout_s = '0;
                    arg_idx_s = 2'd0;
                    state_s   = ST_IDLE;
                end else begin
                    timeout_s = timeout_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_ISSUE: begin
                if (!bus.u_busy) begin
                    u_wr_req_s = is_wr_r;
                    u_rd_req_s = !is_wr_r;
                    u_addr_s   = addr_hold_r;
                    if (is_wr_r) begin
                        u_wdata_s = data_hold_r;
                    end else begin
                        u_wdata_s = u_wdata_r;
                    end
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.u_done) begin
                    tx_valid_s = 1'b1;
                    if (is_wr_r) begin
                        tx_data_s  = ACK_BYTE;
                        resp_two_s = 1'b0;
                    end else begin
                        tx_data_s  = bus.u_rdata[15:8];
                        resp_lo_s  = bus.u_rdata[7:0];
                        resp_two_s = 1'b1;
                    end
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (tx_valid_r && tx_ready) begin
                    if (resp_two_r) begin
                        tx_data_s  = resp_lo_r;
                        resp_two_s = 1'b0;
                    end else begin
                        tx_valid_s = 1'b0;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tx_valid_s = 1'b0;
            end
        endcase

        // Bytes are only consumed in IDLE/ARGS; anything else is lost and flagged.
        if (rx_valid && (state_r != ST_IDLE) && (state_r != ST_ARGS)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_s;
        end
    end

    assign tx_data      = tx_data_r;
    assign tx_valid     = tx_valid_r;
    assign rx_overrun   = overrun_r;
    assign bus.u_req    = u_req_r;
    assign bus.u_wr_req = u_wr_req_r;
    assign bus.u_rd_req = u_rd_req_r;
    assign bus.u_addr   = u_addr_r;
    assign bus.u_wdata  = u_wdata_r;
endmodule

// File: tb/tb_uart_mem_cmd_engine.sv
// Scoreboard bench for uart_mem_cmd_engine: directed frames push expected bridge
// requests and tx bytes; a negedge monitor pops and compares.
module tb_uart_mem_cmd_engine;
    localparam int unsigned TO = 32;

    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic        u_clk;
    logic        u_rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rx_overrun;
    logic        done_model;
    logic        done_spur;
    logic        busy_drv;
    logic [15:0] rdata_val;
    int          done_delay;

    int          tests;
    int          fails;
    int          pulse_cnt;
    req_t        req_q[$];
    logic [7:0]  tx_q[$];

    uart_mem_cmd_engine_if bus ();

    assign bus.u_done = done_model | done_spur;
    assign bus.u_busy = busy_drv;

    uart_mem_cmd_engine #(
        .IDLE_TIMEOUT (TO),
        .ACK_BYTE     (8'h4B),
        .ERR_BYTE     (8'h45)
    ) dut (
        .u_clk      (u_clk),
        .u_rst_n    (u_rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_overrun (rx_overrun),
        .bus        (bus.master)
    );

    initial begin
        u_clk = 1'b0;
        forever #5 u_clk = ~u_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte strobes start at posedge+1 and end at the following posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge u_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge u_clk);
            if (tx_q.size() == 0 && req_q.size() == 0 && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'b0, ok}, 32'd1);
        @(posedge u_clk);
        #1;
    endtask

    // Bridge model: answer each request pulse with u_done after done_delay cycles.
    initial begin
        done_model  = 1'b0;
        bus.u_rdata = 16'h0000;
        forever begin
            @(negedge u_clk);
            if (u_rst_n && (bus.u_wr_req || bus.u_rd_req)) begin
                repeat (done_delay) @(posedge u_clk);
                #1;
                bus.u_rdata = rdata_val;
                done_model  = 1'b1;
                @(posedge u_clk);
                #1;
                done_model  = 1'b0;
            end
        end
    end

    // Monitor: compares bridge requests and tx handshakes against the queues.
    initial begin
        req_t       e;
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge u_clk);
            if (u_rst_n) begin
                if (bus.u_wr_req || bus.u_rd_req) begin
                    pulse_cnt++;
                    check("wr_rd_exclusive", {31'b0, bus.u_wr_req & bus.u_rd_req}, 32'd0);
                    if (req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_req: got wr=%b addr %h, expected none", bus.u_wr_req, bus.u_addr);
                    end else begin
                        e = req_q.pop_front();
                        check("req_kind", {31'b0, bus.u_wr_req}, {31'b0, e.is_wr});
                        check("req_addr", {16'h0000, bus.u_addr}, {16'h0000, e.addr});
                        if (e.is_wr) check("req_wdata", {16'h0000, bus.u_wdata}, {16'h0000, e.wdata});
                    end
                end
                if (prev_stall) begin
                    check("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
                    check("tx_hold_data", {24'h0, tx_data}, {24'h0, prev_data});
                end
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_tx: got %h, expected none", tx_data);
                    end else begin
                        check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int p0;
        logic ok;
        tests      = 0;
        fails      = 0;
        pulse_cnt  = 0;
        u_rst_n    = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b1;
        busy_drv   = 1'b0;
        done_spur  = 1'b0;
        rdata_val  = 16'h0000;
        done_delay = 2;
        repeat (3) @(posedge u_clk);
        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("rst_u_req", {31'b0, bus.u_req}, 32'd0);
        check("rst_pulses", {30'b0, bus.u_wr_req, bus.u_rd_req}, 32'd0);
        check("rst_addr_wdata", {bus.u_addr, bus.u_wdata}, 32'd0);
        check("rst_overrun", {31'b0, rx_overrun}, 32'd0);
        u_rst_n = 1'b1;
        @(posedge u_clk);
        #1;

        // Write 1234 <- BEEF
        req_q.push_back('{1'b1, 16'h1234, 16'hBEEF});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("drain_write", 100);

        // Read 0010 -> A55A
        rdata_val = 16'hA55A;
        req_q.push_back('{1'b0, 16'h0010, 16'h0000});
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_idle("drain_read", 100);

        // Busy held 20 cycles at ISSUE
        busy_drv  = 1'b1;
        rdata_val = 16'h1357;
        p0 = pulse_cnt;
        req_q.push_back('{1'b0, 16'h0020, 16'h0000});
        tx_q.push_back(8'h13);
        tx_q.push_back(8'h57);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
        repeat (20) @(posedge u_clk);
        check("busy_no_pulse", pulse_cnt, p0);
        #1;
        busy_drv = 1'b0;
        @(negedge u_clk);
        check("busy_pulse_not_early", {31'b0, bus.u_rd_req}, 32'd0);
        @(negedge u_clk);
        check("busy_pulse_after_fall", {31'b0, bus.u_rd_req}, 32'd1);
        wait_idle("drain_busy", 100);
        check("busy_one_pulse", pulse_cnt, p0 + 1);

        // tx_ready low for 10 cycles during read response
        tx_ready  = 1'b0;
        rdata_val = 16'hA55A;
        req_q.push_back('{1'b0, 16'h0010, 16'h0000});
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge u_clk);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_tx_valid_rise", {31'b0, ok}, 32'd1);
        repeat (10) @(negedge u_clk);
        check("stall_tx_data_held", {24'h0, tx_data}, 32'h000000A5);
        @(posedge u_clk);
        #1;
        tx_ready = 1'b1;
        wait_idle("drain_stall", 100);

        // Partial frame dropped after TO silent cycles
        p0 = pulse_cnt;
        send_byte(8'h57); send_byte(8'h12);
        repeat (TO) @(posedge u_clk);
        #1;
        check("timeout_no_pulse", pulse_cnt, p0);
        rdata_val = 16'hC3D2;
        req_q.push_back('{1'b0, 16'h0001, 16'h0000});
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'hD2);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        wait_idle("drain_timeout", 100);

        // G / F / unknown opcode
        p0 = pulse_cnt;
        tx_q.push_back(8'h4B);
        send_byte(8'h47);
        wait_idle("drain_g", 50);
        check("g_u_req", {31'b0, bus.u_req}, 32'd1);
        tx_q.push_back(8'h45);
        send_byte(8'h99);
        wait_idle("drain_err", 50);
        check("err_u_req_kept", {31'b0, bus.u_req}, 32'd1);
        tx_q.push_back(8'h4B);
        send_byte(8'h46);
        wait_idle("drain_f", 50);
        check("f_u_req", {31'b0, bus.u_req}, 32'd0);
        check("gf_no_bus_pulse", pulse_cnt, p0);

        // Stray u_done while idle is ignored
        done_spur = 1'b1;
        @(posedge u_clk);
        #1;
        done_spur = 1'b0;
        repeat (5) @(posedge u_clk);
        #1;
        check("stray_done_no_tx", {31'b0, tx_valid}, 32'd0);
        check("overrun_still_clear", {31'b0, rx_overrun}, 32'd0);

        // Byte during WAIT_DONE: overrun set, frame unaffected
        done_delay = 10;
        p0 = pulse_cnt;
        req_q.push_back('{1'b1, 16'h00AA, 16'h1234});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34);
        @(posedge u_clk);
        #1;
        send_byte(8'h52);
        wait_idle("drain_overrun", 100);
        check("overrun_set", {31'b0, rx_overrun}, 32'd1);
        repeat (5) @(posedge u_clk);
        #1;
        check("overrun_one_pulse", pulse_cnt, p0 + 1);
        check("overrun_sticky", {31'b0, rx_overrun}, 32'd1);

        check("req_q_empty", req_q.size(), 32'd0);
        check("tx_q_empty", tx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
